// File: rtl/robo_actuator_sequencer.sv
// robo_actuator_sequencer
// Timed actuator sequencer that sits between the wall-following behaviour FSM
// and the physical drives. Each accepted motion command drives exactly one
// actuator enable for a fixed number of cycles. When the actuator changes from
// the previous command, the block first inserts an all-off dead-time. It also
// keeps a saturating count of completed advances.
//
// Optional feature: define ROBO_SEQ_OVERRIDE_EN to enable the manual-override
// request port. That port has strict priority over the FSM port. When the
// macro is undefined, the manual inputs are ignored and man_ready stays low.

module robo_actuator_sequencer #(
   parameter int MOVE_CYCLES   = 8,
   parameter int TURN_CYCLES   = 12,
   parameter int REMOVE_CYCLES = 16,
   parameter int DEAD_CYCLES   = 2,
   parameter int CNT_W         = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        cmd_valid,
   input  logic [1:0]  cmd_op,
   output logic        cmd_ready,
   input  logic        man_valid,
   input  logic [1:0]  man_op,
   output logic        man_ready,
   input  logic        abort,
   output logic        motor_fwd,
   output logic        motor_turn,
   output logic        arm_on,
   output logic        busy,
   output logic        done,
   output logic        aborted,
   output logic [15:0] adv_count
);

   localparam logic [1:0] OP_NOP     = 2'b00;
   localparam logic [1:0] OP_ADVANCE = 2'b01;
   localparam logic [1:0] OP_TURN    = 2'b10;
   localparam logic [1:0] OP_REMOVE  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      DEAD = 2'b01,
      RUN  = 2'b10,
      DONE = 2'b11
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       op_q, op_d;
   logic [1:0]       last_op_q, last_op_d;
   logic [15:0]      adv_count_q, adv_count_d;
   logic             motor_fwd_q, motor_fwd_d;
   logic             motor_turn_q, motor_turn_d;
   logic             arm_on_q, arm_on_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             aborted_q, aborted_d;

   logic             acc_valid;
   logic [1:0]       acc_op;

   // Returns the on-time of the actuator that the given opcode drives.
   function automatic logic [CNT_W-1:0] run_len(input logic [1:0] op);
      case (op)
         OP_ADVANCE: run_len = CNT_W'(MOVE_CYCLES);
         OP_TURN:    run_len = CNT_W'(TURN_CYCLES);
         default:    run_len = CNT_W'(REMOVE_CYCLES);
      endcase
   endfunction

`ifdef ROBO_SEQ_OVERRIDE_EN
   // Handshake arbitration: in IDLE the manual requester always wins.
   always_comb begin
      man_ready = (state_q == IDLE);
      cmd_ready = (state_q == IDLE) && !man_valid;
      acc_valid = 1'b0;
      acc_op    = OP_NOP;
      if (man_valid && man_ready) begin
         acc_valid = 1'b1;
         acc_op    = man_op;
      end else if (cmd_valid && cmd_ready) begin
         acc_valid = 1'b1;
         acc_op    = cmd_op;
      end
   end
`else
   logic unused_man_inputs;

   // The behaviour FSM is the only requester; the manual port is inert.
   always_comb begin
      unused_man_inputs = ^{man_valid, man_op};
      man_ready         = 1'b0;
      cmd_ready         = (state_q == IDLE);
      acc_valid         = cmd_valid && cmd_ready;
      acc_op            = cmd_op;
   end
`endif

   // Next-state logic: sequencing, dead-time, abort handling and the advance counter.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      op_d        = op_q;
      last_op_d   = last_op_q;
      adv_count_d = adv_count_q;
      aborted_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (acc_valid) begin
               op_d = acc_op;
               if (acc_op == OP_NOP) begin
                  state_d = DONE;
               end else if (acc_op != last_op_q) begin
                  state_d = DEAD;
                  cnt_d   = CNT_W'(DEAD_CYCLES);
               end else begin
                  state_d = RUN;
                  cnt_d   = run_len(acc_op);
               end
            end
         end
         DEAD: begin
            if (abort) begin
               state_d   = IDLE;
               aborted_d = 1'b1;
               last_op_d = OP_NOP;
            end else if (cnt_q == CNT_W'(1)) begin
               state_d = RUN;
               cnt_d   = run_len(op_q);
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RUN: begin
            if (abort) begin
               state_d   = IDLE;
               aborted_d = 1'b1;
               last_op_d = OP_NOP;
            end else if (cnt_q == CNT_W'(1)) begin
               state_d   = DONE;
               last_op_d = op_q;
               if (op_q == OP_ADVANCE && adv_count_q != 16'hFFFF) begin
                  adv_count_d = adv_count_q + 16'd1;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d       = (state_d != IDLE);
      done_d       = (state_d == DONE);
      motor_fwd_d  = (state_d == RUN) && (op_d == OP_ADVANCE);
      motor_turn_d = (state_d == RUN) && (op_d == OP_TURN);
      arm_on_d     = (state_d == RUN) && (op_d == OP_REMOVE);
   end

   // State and registered outputs; reset drops every enable immediately.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         op_q         <= OP_NOP;
         last_op_q    <= OP_NOP;
         adv_count_q  <= 16'd0;
         motor_fwd_q  <= 1'b0;
         motor_turn_q <= 1'b0;
         arm_on_q     <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         aborted_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         op_q         <= op_d;
         last_op_q    <= last_op_d;
         adv_count_q  <= adv_count_d;
         motor_fwd_q  <= motor_fwd_d;
         motor_turn_q <= motor_turn_d;
         arm_on_q     <= arm_on_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         aborted_q    <= aborted_d;
      end
   end

   assign motor_fwd  = motor_fwd_q;
   assign motor_turn = motor_turn_q;
   assign arm_on     = arm_on_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign aborted    = aborted_q;
   assign adv_count  = adv_count_q;

endmodule

// File: tb/tb_robo_actuator_sequencer.sv
// Testbench for robo_actuator_sequencer.
// Cycle-by-cycle vector table plus hand-written saturation and reset sequences.
// The expected manual-override behaviour follows ROBO_SEQ_OVERRIDE_EN.

module tb_robo_actuator_sequencer;

`ifdef ROBO_SEQ_OVERRIDE_EN
   localparam bit OVR = 1'b1;
`else
   localparam bit OVR = 1'b0;
`endif

   logic        clock;
   logic        reset;
   logic        cmd_valid;
   logic [1:0]  cmd_op;
   logic        cmd_ready;
   logic        man_valid;
   logic [1:0]  man_op;
   logic        man_ready;
   logic        abort;
   logic        motor_fwd;
   logic        motor_turn;
   logic        arm_on;
   logic        busy;
   logic        done;
   logic        aborted;
   logic [15:0] adv_count;

   int checks_total;
   int checks_failed;

   typedef struct {
      int          reps;
      logic        cv;
      logic [1:0]  cop;
      logic        mv;
      logic [1:0]  mop;
      logic        ab;
      logic [7:0]  exp_out;
      logic [15:0] exp_cnt;
   } vec_t;

   vec_t vecs[$];

   robo_actuator_sequencer dut (
      .clock      (clock),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_op     (cmd_op),
      .cmd_ready  (cmd_ready),
      .man_valid  (man_valid),
      .man_op     (man_op),
      .man_ready  (man_ready),
      .abort      (abort),
      .motor_fwd  (motor_fwd),
      .motor_turn (motor_turn),
      .arm_on     (arm_on),
      .busy       (busy),
      .done       (done),
      .aborted    (aborted),
      .adv_count  (adv_count)
   );

   // Free-running clock with a 10-unit period.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Watchdog so that the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Adds a run of identical cycles: the inputs to drive, and the outputs expected in those cycles.
   task automatic add(input int reps, input logic cv, input logic [1:0] cop,
                      input logic mv, input logic [1:0] mop, input logic ab,
                      input logic [2:0] en, input logic bsy, input logic dn,
                      input logic abd, input logic cr, input logic idle,
                      input logic [15:0] cnt);
      vec_t v;
      v.reps    = reps;
      v.cv      = cv;
      v.cop     = cop;
      v.mv      = mv;
      v.mop     = mop;
      v.ab      = ab;
      v.exp_out = {en, bsy, dn, abd, cr, idle & OVR};
      v.exp_cnt = cnt;
      vecs.push_back(v);
   endtask

   task automatic applyStimulus(input vec_t v);
      cmd_valid = v.cv;
      cmd_op    = v.cop;
      man_valid = v.mv;
      man_op    = v.mop;
      abort     = v.ab;
   endtask

   task automatic checkOutput(input string name, input logic [15:0] actual,
                              input logic [15:0] expected);
      checks_total++;
      if (actual !== expected) begin
         checks_failed++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   function automatic logic [7:0] out_bus();
      return {motor_fwd, motor_turn, arm_on, busy, done, aborted, cmd_ready, man_ready};
   endfunction

   // Issues one advance from IDLE and waits (bounded) for its done pulse.
   task automatic doAdvance(input string name);
      bit seen;
      cmd_valid = 1'b1;
      cmd_op    = 2'b01;
      @(posedge clock);
      #1;
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      seen      = 1'b0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clock);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      checkOutput({name, "_done"}, {15'd0, seen}, 16'd1);
      @(posedge clock);
      #1;
   endtask

   // Main test sequence.
   initial begin
      checks_total  = 0;
      checks_failed = 0;
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      man_valid = 1'b0;
      man_op    = 2'b00;
      abort     = 1'b0;

      // Advance from reset: 2 dead cycles, 8 cycles of motor_fwd, then done.
      add(1, 1, 2'b01, 0, 2'b00, 0, 3'b000, 0, 0, 0, 1, 1, 16'd0);
      add(2, 0, 2'b00, 0, 2'b00, 0, 3'b000, 1, 0, 0, 0, 0, 16'd0);
      add(8, 0, 2'b00, 0, 2'b00, 0, 3'b100, 1, 0, 0, 0, 0, 16'd0);
      add(1, 0, 2'b00, 0, 2'b00, 0, 3'b000, 1, 1, 0, 0, 0, 16'd1);
      add(1, 0, 2'b00, 0, 2'b00, 0, 3'b000, 0, 0, 0, 1, 1, 16'd1);
      // Two turns: the first gets dead-time, the repeat starts immediately.
      add(1, 1, 2'b10, 0, 2'b00, 0, 3'b000, 0, 0, 0, 1, 1, 16'd1);
      add(2, 0, 2'b00, 0, 2'b00, 0, 3'b000, 1, 0, 0, 0, 0, 16'd1);
      add(12, 0, 2'b00, 0, 2'b00, 0, 3'b010, 1, 0, 0, 0, 0, 16'd1);
      add(1, 0, 2'b00, 0, 2'b00, 0, 3'b000, 1, 1, 0, 0, 0, 16'd1);
      add(1, 1, 2'b10, 0, 2'b00, 0, 3'b000, 0, 0, 0, 1, 1, 16'd1);
      add(12, 0, 2'b00, 0, 2'b00, 0, 3'b010, 1, 0, 0, 0, 0, 16'd1);
      add(1, 0, 2'b00, 0, 2'b00, 0, 3'b000, 1, 1, 0, 0, 0, 16'd1);
      add(1, 0, 2'b00, 0, 2'b00, 0, 3'b000, 0, 0, 0, 1, 1, 16'd1);
      // Remove aborted in its third RUN cycle; the retry then gets dead-time.
      add(1, 1, 2'b11, 0, 2'b00, 0, 3'b000, 0, 0, 0, 1, 1, 16'd1);
      add(2, 0, 2'b00, 0, 2'b00, 0, 3'b000, 1, 0, 0, 0, 0, 16'd1);
      add(2, 0, 2'b00, 0, 2'b00, 0, 3'b001, 1, 0, 0, 0, 0, 16'd1);
      add(1, 0, 2'b00, 0, 2'b00, 1, 3'b001, 1, 0, 0, 0, 0, 16'd1);
      add(1, 0, 2'b00, 0, 2'b00, 0, 3'b000, 0, 0, 1, 1, 1, 16'd1);
      add(1, 1, 2'b11, 0, 2'b00, 0, 3'b000, 0, 0, 0, 1, 1, 16'd1);
      add(2, 0, 2'b00, 0, 2'b00, 0, 3'b000, 1, 0, 0, 0, 0, 16'd1);
      add(16, 0, 2'b00, 0, 2'b00, 0, 3'b001, 1, 0, 0, 0, 0, 16'd1);
      add(1, 0, 2'b00, 0, 2'b00, 1, 3'b000, 1, 1, 0, 0, 0, 16'd1);
      add(1, 0, 2'b00, 0, 2'b00, 0, 3'b000, 0, 0, 0, 1, 1, 16'd1);
      // Nop completes next cycle and leaves last_op alone, so the remove repeat has no dead-time.
      add(1, 1, 2'b00, 0, 2'b00, 0, 3'b000, 0, 0, 0, 1, 1, 16'd1);
      add(1, 0, 2'b00, 0, 2'b00, 0, 3'b000, 1, 1, 0, 0, 0, 16'd1);
      add(1, 1, 2'b11, 0, 2'b00, 0, 3'b000, 0, 0, 0, 1, 1, 16'd1);
      add(16, 0, 2'b00, 0, 2'b00, 0, 3'b001, 1, 0, 0, 0, 0, 16'd1);
      add(1, 0, 2'b00, 0, 2'b00, 0, 3'b000, 1, 1, 0, 0, 0, 16'd1);
      add(1, 0, 2'b00, 0, 2'b00, 0, 3'b000, 0, 0, 0, 1, 1, 16'd1);
`ifdef ROBO_SEQ_OVERRIDE_EN
      // Manual remove beats the held FSM advance; the advance follows with dead-time.
      add(1, 1, 2'b01, 1, 2'b11, 0, 3'b000, 0, 0, 0, 0, 1, 16'd1);
      add(16, 1, 2'b01, 0, 2'b00, 0, 3'b001, 1, 0, 0, 0, 0, 16'd1);
      add(1, 1, 2'b01, 0, 2'b00, 0, 3'b000, 1, 1, 0, 0, 0, 16'd1);
      add(1, 1, 2'b01, 0, 2'b00, 0, 3'b000, 0, 0, 0, 1, 1, 16'd1);
      add(2, 0, 2'b00, 0, 2'b00, 0, 3'b000, 1, 0, 0, 0, 0, 16'd1);
      add(8, 0, 2'b00, 0, 2'b00, 0, 3'b100, 1, 0, 0, 0, 0, 16'd1);
      add(1, 0, 2'b00, 0, 2'b00, 0, 3'b000, 1, 1, 0, 0, 0, 16'd2);
      add(1, 0, 2'b00, 0, 2'b00, 0, 3'b000, 0, 0, 0, 1, 1, 16'd2);
`else
      // Manual port is inert: no motion, and the FSM turn proceeds normally.
      add(3, 0, 2'b00, 1, 2'b01, 0, 3'b000, 0, 0, 0, 1, 1, 16'd1);
      add(1, 1, 2'b10, 1, 2'b01, 0, 3'b000, 0, 0, 0, 1, 1, 16'd1);
      add(2, 0, 2'b00, 1, 2'b01, 0, 3'b000, 1, 0, 0, 0, 0, 16'd1);
      add(12, 0, 2'b00, 1, 2'b01, 0, 3'b010, 1, 0, 0, 0, 0, 16'd1);
      add(1, 0, 2'b00, 1, 2'b01, 0, 3'b000, 1, 1, 0, 0, 0, 16'd1);
      add(1, 0, 2'b00, 0, 2'b00, 0, 3'b000, 0, 0, 0, 1, 1, 16'd1);
`endif

      // Check the reset state while reset is held.
      repeat (2) @(posedge clock);
      @(negedge clock);
      checkOutput("reset_outputs", {8'd0, out_bus()}, {8'd0, 6'b000000, 1'b1, OVR});
      checkOutput("reset_adv_count", adv_count, 16'd0);
      reset = 1'b0;
      @(posedge clock);
      #1;

      // Table-driven cycle checks.
      for (int i = 0; i < vecs.size(); i++) begin
         for (int r = 0; r < vecs[i].reps; r++) begin
            applyStimulus(vecs[i]);
            @(negedge clock);
            checkOutput($sformatf("vec%0d.%0d_outputs", i, r), {8'd0, out_bus()},
                        {8'd0, vecs[i].exp_out});
            checkOutput($sformatf("vec%0d.%0d_adv_count", i, r), adv_count, vecs[i].exp_cnt);
            @(posedge clock);
            #1;
         end
      end
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      man_valid = 1'b0;
      man_op    = 2'b00;
      abort     = 1'b0;

      // Saturation: preload the counter near full, then step it to full and past.
      @(negedge clock);
      force dut.adv_count_q = 16'hFFFE;
      #1;
      release dut.adv_count_q;
      @(posedge clock);
      #1;
      doAdvance("sat_first");
      checkOutput("sat_reach_max", adv_count, 16'hFFFF);
      doAdvance("sat_second");
      checkOutput("sat_hold_max", adv_count, 16'hFFFF);

      // Asynchronous reset in the middle of a turn drops the enable at once.
      cmd_valid = 1'b1;
      cmd_op    = 2'b10;
      @(posedge clock);
      #1;
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      repeat (4) @(posedge clock);
      #1;
      checkOutput("midrun_turn_on", {15'd0, motor_turn}, 16'd1);
      #1;
      reset = 1'b1;
      #1;
      checkOutput("async_reset_outputs", {8'd0, out_bus()}, {8'd0, 6'b000000, 1'b1, OVR});
      checkOutput("async_reset_adv_count", adv_count, 16'd0);
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      #1;

      $display("%0d/%0d checks passed", checks_total - checks_failed, checks_total);
      $finish;
   end

endmodule
